// File: rtl/uart_rx_loader.sv
// uart_rx_loader: 8N1 UART receiver (16x oversampling) feeding a boot loader
// that packs little-endian bytes into 32-bit words and writes them to
// instruction memory at consecutive word addresses until END_MARKER arrives.
module uart_rx_loader #(
  parameter int          CLK_FREQ   = 50000000,
  parameter int          BAUD       = 19200,
  parameter int          OVERSAMPLE = 16,
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              load_en,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              frame_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              done
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;
  logic [1:0]       r_state;
  logic [3:0]       r_tick_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]      w_word_full;

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values
      // on the same edge; blocking here would collapse the chain to one flop.
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Free-running divider producing a one-cycle oversampling tick every DIV clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_W'(DIV - 1)) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  // Receiver FSM: start-bit qualification at mid-bit, 8 data bits LSB first,
  // stop-bit check producing either byte_valid or frame_err for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_tick_cnt <= '0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd7) begin
              r_tick_cnt <= '0;
              r_bit_idx  <= '0;
              // A high level at mid start bit was only a glitch.
              r_state    <= r_rx_sync ? S_IDLE : S_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd15) begin
              r_tick_cnt <= '0;
              r_shift    <= {r_rx_sync, r_shift[7:1]};
              if (r_bit_idx == 3'd7) begin
                r_state <= S_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd15) begin
              r_tick_cnt <= '0;
              if (r_rx_sync) begin
                byte_data  <= r_shift;
                byte_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              r_state <= S_IDLE;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The fourth byte is combined with the three stored ones so the full word
  // can be compared and written without an extra pipeline stage.
  assign w_word_full = {byte_data, r_word};

  // Word assembler and instruction-memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_addr     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      done       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (!load_en) begin
        r_byte_cnt <= '0;
        r_word     <= '0;
        r_addr     <= '0;
        done       <= 1'b0;
      end else if (byte_valid && !done) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0: r_word[7:0]   <= byte_data;
          2'd1: r_word[15:8]  <= byte_data;
          2'd2: r_word[23:16] <= byte_data;
          default: begin
            if (w_word_full == END_MARKER) begin
              done <= 1'b1;
            end else begin
              mem_we   <= 1'b1;
              mem_data <= w_word_full;
              mem_addr <= r_addr;
              r_addr   <= r_addr + ADDR_W'(4);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed testbench for uart_rx_loader: 64 clocks per bit (DIV = 4).
module tb_uart_rx_loader;

  localparam int BAUD     = 19200;
  localparam int CLK_FREQ = 64 * BAUD;
  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        load_en;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        done;

  uart_rx_loader #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(16),
    .ADDR_W    (32),
    .END_MARKER(32'hFFFF_FFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .load_en   (load_en),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Event log filled on the falling edge, away from DUT updates.
  int          cyc = 0;
  int          bv_cnt = 0;
  int          fe_cnt = 0;
  int          we_cnt = 0;
  int          last_bv_cyc = 0;
  logic [7:0]  last_byte = 8'h00;
  logic [31:0] we_addr [32];
  logic [31:0] we_data [32];
  int          we_gap  [32];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_we && we_cnt < 32) begin
      we_addr[we_cnt] = mem_addr;
      we_data[we_cnt] = mem_data;
      we_gap[we_cnt]  = cyc - last_bv_cyc;
    end
    if (mem_we) we_cnt = we_cnt + 1;
    if (byte_valid) begin
      bv_cnt      = bv_cnt + 1;
      last_byte   = byte_data;
      last_bv_cyc = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; a bad stop bit is held low only long enough to cover
  // the mid-bit sample so the line recovers before the next frame.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT_CLKS);
    end
    if (stop_ok) begin
      rx = 1'b1;
      idle(BIT_CLKS);
    end else begin
      rx = 1'b0;
      idle(48);
      rx = 1'b1;
      idle(BIT_CLKS);
    end
    idle(16);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({pfx, "_byte_data"},  32'(byte_data),  32'd0);
    check({pfx, "_frame_err"},  32'(frame_err),  32'd0);
    check({pfx, "_mem_we"},     32'(mem_we),     32'd0);
    check({pfx, "_mem_addr"},   mem_addr,        32'd0);
    check({pfx, "_mem_data"},   mem_data,        32'd0);
    check({pfx, "_done"},       32'(done),       32'd0);
  endtask

  int bv0, fe0, we0;

  initial begin
    rx      = 1'b1;
    load_en = 1'b0;
    reset   = 1'b1;
    idle(5);
    check_all_zero("rst");
    reset = 1'b0;
    idle(10);

    // Byte received with the loader disabled: pulse only, no write.
    bv0 = bv_cnt; we0 = we_cnt;
    send_byte(8'h55, 1'b1);
    check("t1_bv_count", bv_cnt - bv0, 32'd1);
    check("t1_byte",     {24'd0, last_byte}, 32'h55);
    check("t1_we_count", we_cnt - we0, 32'd0);
    check("t1_done",     32'(done), 32'd0);

    // Two words at consecutive addresses.
    load_en = 1'b1;
    idle(4);
    we0 = we_cnt;
    send_word(32'h2022_0013);
    send_word(32'h1000_0008);
    idle(8);
    check("t2_we_count", we_cnt - we0, 32'd2);
    check("t2_addr0",    we_addr[we0], 32'h0);
    check("t2_data0",    we_data[we0], 32'h2022_0013);
    check("t2_gap0",     we_gap[we0], 32'd1);
    check("t2_addr1",    we_addr[we0+1], 32'h4);
    check("t2_data1",    we_data[we0+1], 32'h1000_0008);
    check("t2_gap1",     we_gap[we0+1], 32'd1);
    check("t2_we_low",   32'(mem_we), 32'd0);
    check("t2_addr_hold", mem_addr, 32'h4);
    check("t2_data_hold", mem_data, 32'h1000_0008);

    // Framing error does not consume a byte slot.
    load_en = 1'b0;
    idle(4);
    load_en = 1'b1;
    idle(4);
    bv0 = bv_cnt; fe0 = fe_cnt; we0 = we_cnt;
    send_byte(8'h13, 1'b0);
    send_word(32'h2022_0013);
    idle(8);
    check("t3_fe_count", fe_cnt - fe0, 32'd1);
    check("t3_bv_count", bv_cnt - bv0, 32'd4);
    check("t3_we_count", we_cnt - we0, 32'd1);
    check("t3_addr",     we_addr[we0], 32'h0);
    check("t3_data",     we_data[we0], 32'h2022_0013);

    // Short low pulse is rejected as a glitch; next frame is fine.
    bv0 = bv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(3 * BIT_CLKS);
    check("t4_glitch_bv", bv_cnt - bv0, 32'd0);
    check("t4_glitch_fe", fe_cnt - fe0, 32'd0);
    send_byte(8'hA5, 1'b1);
    check("t4_bv_count", bv_cnt - bv0, 32'd1);
    check("t4_byte",     {24'd0, last_byte}, 32'hA5);

    // End marker stops loading; receiver keeps running.
    load_en = 1'b0;
    idle(4);
    load_en = 1'b1;
    idle(4);
    send_word(32'h2022_0013);
    idle(8);
    we0 = we_cnt; bv0 = bv_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b1);
    check("t5_done_early", 32'(done), 32'd0);
    send_byte(8'hFF, 1'b1);
    check("t5_done_set",   32'(done), 32'd1);
    send_word(32'h0403_0201);
    idle(8);
    check("t5_we_count",   we_cnt - we0, 32'd0);
    check("t5_bv_count",   bv_cnt - bv0, 32'd8);
    check("t5_done_stick", 32'(done), 32'd1);

    // Reset in the middle of the data bits aborts the frame.
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      idle(BIT_CLKS);
    end
    rx = 1'b1;
    idle(BIT_CLKS / 2);
    reset = 1'b1;
    idle(3);
    check_all_zero("t6_rst");
    idle(5);
    reset = 1'b0;
    idle(2 * BIT_CLKS);
    bv0 = bv_cnt; fe0 = fe_cnt;
    send_byte(8'h3C, 1'b1);
    check("t6_bv_count", bv_cnt - bv0, 32'd1);
    check("t6_fe_count", fe_cnt - fe0, 32'd0);
    check("t6_byte",     {24'd0, last_byte}, 32'h3C);
    check("t6_byte_out", 32'(byte_data), 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
